regalu_datapath: RTL and testbench



---
 rtl/cpu_pkg.sv | 15 +
 rtl/gpr_bank.sv | 36 +++
 rtl/regalu_datapath.sv | 64 ++++++
 tb/tb_regalu_datapath.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and ALU opcode encoding for the 8-bit single-cycle CPU.
// Imported by the register bank and the execution datapath.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [2:0] {
        ALU_FWD = 3'b000,
        ALU_ADD = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } aluop_e;

endpackage

// File: rtl/gpr_bank.sv
// General-purpose register array: sync reset, one write port,
// two asynchronous read ports with no write-to-read bypass.
module gpr_bank #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Reset wins over a simultaneous write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/regalu_datapath.sv
// Register file plus combinational ALU; result written back on CLK.
// Optional ZERO flag output when ALU_ZERO_FLAG_EN is defined.
module regalu_datapath #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WRITEENABLE,
    input  logic [ADDR_W-1:0] WRITEREG,
    input  logic [ADDR_W-1:0] READREG1,
    input  logic [ADDR_W-1:0] READREG2,
    input  logic [2:0]        ALUOP,
    input  logic [DATA_W-1:0] OPERAND2,
`ifdef ALU_ZERO_FLAG_EN
    output logic              ZERO,
`endif
    output logic [DATA_W-1:0] REGOUT1,
    output logic [DATA_W-1:0] REGOUT2,
    output logic [DATA_W-1:0] ALU_RESULT
);

    import cpu_pkg::*;

    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_result;

    gpr_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_gpr (
        .i_clk    (CLK),
        .i_rst    (RESET),
        .i_we     (WRITEENABLE),
        .i_waddr  (WRITEREG),
        .i_wdata  (w_result),
        .i_raddr1 (READREG1),
        .i_raddr2 (READREG2),
        .o_rdata1 (w_rd1),
        .o_rdata2 (w_rd2)
    );

    // Carry out of ADD is dropped; reserved opcodes yield zero.
    always_comb begin
        w_result = '0;
        case (ALUOP)
            ALU_FWD: w_result = OPERAND2;
            ALU_ADD: w_result = w_rd1 + OPERAND2;
            ALU_AND: w_result = w_rd1 & OPERAND2;
            ALU_OR:  w_result = w_rd1 | OPERAND2;
            default: w_result = '0;
        endcase
    end

    assign REGOUT1    = w_rd1;
    assign REGOUT2    = w_rd2;
    assign ALU_RESULT = w_result;

`ifdef ALU_ZERO_FLAG_EN
    assign ZERO = (w_result == '0);
`endif

endmodule

// File: tb/tb_regalu_datapath.sv
// Randomized self-checking bench for regalu_datapath against a
// behavioural register-file/ALU model.
module tb_regalu_datapath;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       WRITEENABLE = 1'b0;
    logic [2:0] WRITEREG = '0;
    logic [2:0] READREG1 = '0;
    logic [2:0] READREG2 = '0;
    logic [2:0] ALUOP = '0;
    logic [7:0] OPERAND2 = '0;
    logic [7:0] REGOUT1;
    logic [7:0] REGOUT2;
    logic [7:0] ALU_RESULT;
`ifdef ALU_ZERO_FLAG_EN
    logic       ZERO;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mreg [8];
    bit         m_valid = 1'b0;

    regalu_datapath dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .WRITEENABLE (WRITEENABLE),
        .WRITEREG    (WRITEREG),
        .READREG1    (READREG1),
        .READREG2    (READREG2),
        .ALUOP       (ALUOP),
        .OPERAND2    (OPERAND2),
`ifdef ALU_ZERO_FLAG_EN
        .ZERO        (ZERO),
`endif
        .REGOUT1     (REGOUT1),
        .REGOUT2     (REGOUT2),
        .ALU_RESULT  (ALU_RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] alu_ref(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [2:0] op);
        int s;
        case (op)
            3'd0: return b;
            3'd1: begin
                s = int'(a) + int'(b);
                return 8'(s % 256);
            end
            3'd2: return a & b;
            3'd3: return a | b;
            default: return 8'h00;
        endcase
    endfunction

    task automatic drive(input logic rst, input logic we,
                         input logic [2:0] wr, input logic [2:0] rr1,
                         input logic [2:0] rr2, input logic [2:0] op,
                         input logic [7:0] op2);
        logic [7:0] e;
        RESET       = rst;
        WRITEENABLE = we;
        WRITEREG    = wr;
        READREG1    = rr1;
        READREG2    = rr2;
        ALUOP       = op;
        OPERAND2    = op2;
        #2;
        if (m_valid) begin
            e = alu_ref(mreg[rr1], op2, op);
            check("rd1", REGOUT1, mreg[rr1]);
            check("rd2", REGOUT2, mreg[rr2]);
            check("alu", ALU_RESULT, e);
`ifdef ALU_ZERO_FLAG_EN
            check("zero", {7'b0, ZERO}, {7'b0, (e == 8'h00)});
`endif
        end
    endtask

    task automatic tick;
        logic [7:0] wv;
        wv = alu_ref(mreg[READREG1], OPERAND2, ALUOP);
        @(posedge CLK);
        if (RESET) begin
            for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
            m_valid = 1'b1;
        end else if (WRITEENABLE && m_valid) begin
            mreg[WRITEREG] = wv;
        end
        #1;
    endtask

    initial begin
        // Reset wins over a write of AA to r2.
        drive(1, 1, 3'd2, 3'd0, 3'd0, 3'd0, 8'hAA);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 3'd0, 3'(i), 3'(i), 3'd0, 8'h00);
            check("rst_reg", REGOUT1, 8'h00);
        end

        // FORWARD write to r1.
        drive(0, 1, 3'd1, 3'd0, 3'd0, 3'd0, 8'h05);
        check("fwd_alu", ALU_RESULT, 8'h05);
        tick();
        drive(0, 0, 3'd0, 3'd1, 3'd0, 3'd0, 8'h00);
        check("fwd_r1", REGOUT1, 8'h05);
        for (int i = 2; i < 8; i++) begin
            drive(0, 0, 3'd0, 3'd0, 3'(i), 3'd0, 8'h00);
            check("fwd_other", REGOUT2, 8'h00);
        end

        // ADD wraparound, then r3 = 5 + 0A.
        drive(0, 0, 3'd0, 3'd1, 3'd0, 3'd1, 8'hFB);
        check("add_wrap", ALU_RESULT, 8'h00);
        drive(0, 1, 3'd3, 3'd1, 3'd0, 3'd1, 8'h0A);
        tick();
        drive(0, 0, 3'd0, 3'd3, 3'd0, 3'd0, 8'h00);
        check("add_r3", REGOUT1, 8'h0F);

        // AND / OR / reserved with r1 = F0.
        drive(0, 1, 3'd1, 3'd0, 3'd0, 3'd0, 8'hF0);
        tick();
        drive(0, 0, 3'd0, 3'd1, 3'd0, 3'd2, 8'h3C);
        check("and", ALU_RESULT, 8'h30);
        drive(0, 0, 3'd0, 3'd1, 3'd0, 3'd3, 8'h3C);
        check("or", ALU_RESULT, 8'hFC);
        drive(0, 0, 3'd0, 3'd1, 3'd0, 3'd5, 8'h3C);
        check("rsvd", ALU_RESULT, 8'h00);

        // Write disabled leaves r1 intact.
        drive(0, 0, 3'd1, 3'd0, 3'd0, 3'd0, 8'h77);
        tick();
        drive(0, 0, 3'd0, 3'd1, 3'd0, 3'd0, 8'h00);
        check("we0_r1", REGOUT1, 8'hF0);

        // Old value visible until the edge, new value after.
        drive(0, 1, 3'd4, 3'd0, 3'd0, 3'd0, 8'h11);
        tick();
        drive(0, 1, 3'd4, 3'd0, 3'd4, 3'd0, 8'h22);
        check("rdw_old", REGOUT2, 8'h11);
        tick();
        drive(0, 0, 3'd0, 3'd0, 3'd4, 3'd0, 8'h00);
        check("rdw_new", REGOUT2, 8'h22);

        // Dual read of r3.
        drive(0, 0, 3'd0, 3'd3, 3'd3, 3'd0, 8'h00);
        check("dual1", REGOUT1, 8'h0F);
        check("dual2", REGOUT2, 8'h0F);

        // r1 = r1 + 1 through its own read port.
        drive(0, 1, 3'd1, 3'd1, 3'd0, 3'd1, 8'h01);
        tick();
        drive(0, 0, 3'd0, 3'd1, 3'd0, 3'd0, 8'h00);
        check("self_inc", REGOUT1, 8'hF1);

        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 3) != 0),
                  3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0) ?
                      3'($urandom_range(4, 7)) :
                      3'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)));
            tick();
        end
        drive(0, 0, 3'd0, 3'd0, 3'd7, 3'd1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
